// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported memory between the IF stage (instruction reads)
//   and the MEM stage (loads and stores). Only one access is in flight at a
//   time. A data request wins over an instruction request when both are
//   waiting in the same idle cycle.
//
//   Once an access is granted, its address, write strobe and write data are
//   captured. They are then driven unchanged onto the memory port until the
//   memory acknowledges the access or the wait counter expires. On
//   completion, read data is registered into the requester's result
//   register. A one-cycle done flag then releases that requester's stall.
//
//   If no acknowledge arrives within TIMEOUT grant cycles, the access is
//   aborted. The requester still sees a done cycle, with a zero result,
//   and bus_err pulses for that cycle.
//
// Parameters:
//   TIMEOUT     maximum number of grant cycles to wait for mem_ack (>= 1)
//
// Ports:
//   clk         in   1   clock, all state changes on the rising edge
//   rst_n       in   1   synchronous active-low reset
//   inst_req    in   1   IF stage instruction read request
//   inst_addr   in   32  instruction byte address
//   inst_data   out  32  registered instruction read result
//   inst_stall  out  1   IF stage must hold
//   data_ren    in   1   MEM stage load request
//   data_wen    in   1   MEM stage store request (wins over data_ren)
//   data_addr   in   32  data byte address
//   data_wdata  in   32  store data
//   data_rdata  out  32  registered load result
//   mem_stall   out  1   MEM stage must hold
//   mem_cs      out  1   shared memory port select
//   mem_we      out  1   shared memory port write strobe
//   mem_addr    out  32  shared memory port address
//   mem_wdata   out  32  shared memory port write data
//   mem_rdata   in   32  read data from memory
//   mem_ack     in   1   access completion from memory
//   bus_err     out  1   one-cycle pulse when an access is aborted on timeout
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   output logic        inst_stall,
   input  logic        data_ren,
   input  logic        data_wen,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        mem_stall,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        bus_err
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] GNT_DATA = 2'd1;
   localparam logic [1:0] GNT_INST = 2'd2;

   // The counter is at least 8 bits wide, and wider when TIMEOUT needs it.
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;
   logic [CNT_W-1:0] r_waitCnt;
   logic             r_memWe;
   logic [31:0]      r_memAddr;
   logic [31:0]      r_memWdata;
   logic [31:0]      r_instData;
   logic [31:0]      r_dataRdata;
   logic             r_instDone;
   logic             r_dataDone;
   logic             r_busErr;

   logic             w_dataReq;
   logic             w_granted;
   logic             w_expire;
   logic             w_finish;
   logic             w_grantData;
   logic             w_grantInst;

   // A load and a store are both a single data request. The port counts as
   // busy in either grant state. The access expires in the last allowed
   // grant cycle, but only when the memory does not acknowledge in that
   // same cycle: an acknowledge always wins over the timeout.
   assign w_dataReq = data_ren | data_wen;
   assign w_granted = (r_state != IDLE);
   assign w_expire  = w_granted & ~mem_ack & (r_waitCnt == TIMEOUT_M1);
   assign w_finish  = w_granted & (mem_ack | w_expire);

   // Next-state selection. In idle, a pending data request goes first. The
   // done flags block a request that is still held during its own done
   // cycle, so that the access is not issued twice. If the request is still
   // held one cycle later, it is treated as a new access.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_dataReq && !r_dataDone) begin
               w_nextState = GNT_DATA;
            end else if (inst_req && !r_instDone) begin
               w_nextState = GNT_INST;
            end
         end
         GNT_DATA, GNT_INST: begin
            if (w_finish) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   assign w_grantData = (r_state == IDLE) && (w_nextState == GNT_DATA);
   assign w_grantInst = (r_state == IDLE) && (w_nextState == GNT_INST);

   // State register. Reset returns to idle at once, so mem_cs drops in the
   // cycle after reset is seen. Any late acknowledge then arrives in idle
   // and is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Request capture. The address, write strobe and write data are sampled
   // only at grant. The memory port then stays stable for the whole access,
   // even if the requester changes or withdraws its inputs. A request with
   // both data_ren and data_wen set is a store. Instruction fetches never
   // write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_memWe    <= 1'b0;
         r_memAddr  <= 32'h0;
         r_memWdata <= 32'h0;
      end else if (w_grantData) begin
         r_memWe    <= data_wen;
         r_memAddr  <= data_addr;
         r_memWdata <= data_wdata;
      end else if (w_grantInst) begin
         r_memWe    <= 1'b0;
         r_memAddr  <= inst_addr;
         r_memWdata <= 32'h0;
      end
   end

   // Wait counter. It starts from zero at each grant and counts the grant
   // cycles that pass without an acknowledge. Once the access ends, the
   // value left in it does not matter until the next grant clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_waitCnt <= '0;
      end else if (w_grantData || w_grantInst) begin
         r_waitCnt <= '0;
      end else if (w_granted && !mem_ack) begin
         r_waitCnt <= r_waitCnt + CNT_W'(1);
      end
   end

   // Result registers. A completed read loads the memory data into the
   // requester's register. A completed store leaves data_rdata unchanged.
   // An aborted access loads zero, so a stale value is never mistaken for
   // fresh data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instData  <= 32'h0;
         r_dataRdata <= 32'h0;
      end else begin
         if (r_state == GNT_INST) begin
            if (mem_ack) begin
               r_instData <= mem_rdata;
            end else if (w_expire) begin
               r_instData <= 32'h0;
            end
         end
         if (r_state == GNT_DATA) begin
            if (mem_ack && !r_memWe) begin
               r_dataRdata <= mem_rdata;
            end else if (w_expire) begin
               r_dataRdata <= 32'h0;
            end
         end
      end
   end

   // Done flags and the bus error pulse. All three are high only in the
   // cycle right after an access ends. They clear by themselves because
   // the next access cannot end in the cycle in which it is granted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instDone <= 1'b0;
         r_dataDone <= 1'b0;
         r_busErr   <= 1'b0;
      end else begin
         r_instDone <= (r_state == GNT_INST) && w_finish;
         r_dataDone <= (r_state == GNT_DATA) && w_finish;
         r_busErr   <= w_expire;
      end
   end

   // Stalls follow the request inputs in the same cycle, so a requester
   // sees its stall at once. The stalls are forced low while reset is
   // asserted, so the pipeline does not hold on a request the arbiter is
   // not serving.
   assign inst_stall = rst_n & inst_req & ~r_instDone;
   assign mem_stall  = rst_n & w_dataReq & ~r_dataDone;

   assign mem_cs     = w_granted;
   assign mem_we     = r_memWe;
   assign mem_addr   = r_memAddr;
   assign mem_wdata  = r_memWdata;
   assign inst_data  = r_instData;
   assign data_rdata = r_dataRdata;
   assign bus_err    = r_busErr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter, with TIMEOUT set to 4.
// A table of single-cycle vectors covers reset, a single fetch, data
// priority, an acknowledge arriving in idle, re-issue of a held request and
// a request withdrawn while granted. Hand-written sequences cover the
// store, the timeout abort, an acknowledge that coincides with the timeout,
// and reset during an access. A random phase is then checked against a
// transaction-level model of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 4;

   logic        clk;
   logic        rst_n;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        inst_stall;
   logic        data_ren;
   logic        data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        mem_stall;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        bus_err;

   int totalCount = 0;
   int badCount   = 0;

   typedef struct {
      logic        rstN;
      logic        instReq;
      logic [31:0] instAddr;
      logic        dataRen;
      logic        dataWen;
      logic [31:0] dataAddr;
      logic [31:0] dataWdata;
      logic        memAck;
      logic [31:0] memRdata;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        expCs;
      logic        expWe;
      logic [31:0] expAddr;
      logic        expIStall;
      logic        expMStall;
      logic        expErr;
      logic [31:0] expIData;
      logic [31:0] expDRdata;
   } vec_t;

   // Transaction-level model: describes the access in flight, not the FSM.
   logic        mActive;
   logic        mIsData;
   logic [31:0] mAddr;
   logic        mWe;
   logic [31:0] mWdata;
   int          mAge;
   logic        mInstDone;
   logic        mDataDone;
   logic        mErr;
   logic [31:0] mInstData;
   logic [31:0] mDataRdata;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_data  (inst_data),
      .inst_stall (inst_stall),
      .data_ren   (data_ren),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .mem_stall  (mem_stall),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .bus_err    (bus_err)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t mkS(input logic rstN, input logic iReq, input logic [31:0] iAddr,
                                 input logic dRen, input logic dWen, input logic [31:0] dAddr,
                                 input logic [31:0] dWdata, input logic ack, input logic [31:0] rdata);
      stim_t s;
      s.rstN      = rstN;
      s.instReq   = iReq;
      s.instAddr  = iAddr;
      s.dataRen   = dRen;
      s.dataWen   = dWen;
      s.dataAddr  = dAddr;
      s.dataWdata = dWdata;
      s.memAck    = ack;
      s.memRdata  = rdata;
      return s;
   endfunction

   function automatic vec_t mkV(input stim_t s, input logic cs, input logic we, input logic [31:0] addr,
                                input logic iStall, input logic mStall, input logic err,
                                input logic [31:0] iData, input logic [31:0] dRdata);
      vec_t v;
      v.s         = s;
      v.expCs     = cs;
      v.expWe     = we;
      v.expAddr   = addr;
      v.expIStall = iStall;
      v.expMStall = mStall;
      v.expErr    = err;
      v.expIData  = iData;
      v.expDRdata = dRdata;
      return v;
   endfunction

   task automatic applyStimulus(input stim_t s);
      rst_n      = s.rstN;
      inst_req   = s.instReq;
      inst_addr  = s.instAddr;
      data_ren   = s.dataRen;
      data_wen   = s.dataWen;
      data_addr  = s.dataAddr;
      data_wdata = s.dataWdata;
      mem_ack    = s.memAck;
      mem_rdata  = s.memRdata;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance the model across one rising edge, using the inputs applied in
   // the cycle before the edge.
   task automatic modelUpdate(input stim_t s);
      logic nI;
      logic nD;
      logic nE;
      nI = 1'b0;
      nD = 1'b0;
      nE = 1'b0;
      if (!s.rstN) begin
         mActive    = 1'b0;
         mInstData  = 32'h0;
         mDataRdata = 32'h0;
      end else if (mActive) begin
         if (s.memAck) begin
            if (mIsData) begin
               if (!mWe) mDataRdata = s.memRdata;
               nD = 1'b1;
            end else begin
               mInstData = s.memRdata;
               nI = 1'b1;
            end
            mActive = 1'b0;
         end else if (mAge + 1 == TIMEOUT) begin
            if (mIsData) begin
               mDataRdata = 32'h0;
               nD = 1'b1;
            end else begin
               mInstData = 32'h0;
               nI = 1'b1;
            end
            nE = 1'b1;
            mActive = 1'b0;
         end else begin
            mAge++;
         end
      end else if ((s.dataRen || s.dataWen) && !mDataDone) begin
         mActive = 1'b1;
         mIsData = 1'b1;
         mAddr   = s.dataAddr;
         mWe     = s.dataWen;
         mWdata  = s.dataWdata;
         mAge    = 0;
      end else if (s.instReq && !mInstDone) begin
         mActive = 1'b1;
         mIsData = 1'b0;
         mAddr   = s.instAddr;
         mWe     = 1'b0;
         mWdata  = 32'h0;
         mAge    = 0;
      end
      mInstDone = nI;
      mDataDone = nD;
      mErr      = nE;
   endtask

   initial begin : mainTest
      vec_t  vecs[14];
      stim_t s;
      stim_t z;

      z = mkS(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

      // rst, ireq, iaddr, dren, dwen, daddr, dwdata, ack, rdata | cs, we, addr, istall, mstall, err, idata, drdata
      vecs[0]  = mkV(mkS(0, 1, 32'h40, 1, 0, 32'h100, 0, 0, 0),            0, 0, 32'h0,   0, 0, 0, 32'h0,        32'h0);
      vecs[1]  = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),                  0, 0, 32'h0,   1, 0, 0, 32'h0,        32'h0);
      vecs[2]  = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h2108000A),       1, 0, 32'h40,  1, 0, 0, 32'h0,        32'h0);
      vecs[3]  = mkV(mkS(1, 1, 32'h44, 0, 0, 0, 0, 0, 0),                  0, 0, 32'h40,  0, 0, 0, 32'h2108000A, 32'h0);
      vecs[4]  = mkV(mkS(1, 0, 32'h0, 0, 0, 0, 0, 0, 0),                   0, 0, 32'h40,  0, 0, 0, 32'h2108000A, 32'h0);
      vecs[5]  = mkV(mkS(1, 1, 32'h40, 1, 0, 32'h100, 0, 0, 0),            0, 0, 32'h40,  1, 1, 0, 32'h2108000A, 32'h0);
      vecs[6]  = mkV(mkS(1, 1, 32'h40, 1, 0, 32'h100, 0, 1, 32'h11112222), 1, 0, 32'h100, 1, 1, 0, 32'h2108000A, 32'h0);
      vecs[7]  = mkV(mkS(1, 1, 32'h40, 1, 0, 32'h100, 0, 0, 0),            0, 0, 32'h100, 1, 0, 0, 32'h2108000A, 32'h11112222);
      vecs[8]  = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'h33334444),       1, 0, 32'h40,  1, 0, 0, 32'h2108000A, 32'h11112222);
      vecs[9]  = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),                  0, 0, 32'h40,  0, 0, 0, 32'h33334444, 32'h11112222);
      vecs[10] = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 1, 32'hDEADBEEF),       0, 0, 32'h40,  1, 0, 0, 32'h33334444, 32'h11112222);
      vecs[11] = mkV(mkS(1, 1, 32'h40, 0, 0, 0, 0, 0, 0),                  1, 0, 32'h40,  1, 0, 0, 32'h33334444, 32'h11112222);
      vecs[12] = mkV(mkS(1, 0, 32'h0, 0, 0, 0, 0, 1, 32'h55556666),        1, 0, 32'h40,  0, 0, 0, 32'h33334444, 32'h11112222);
      vecs[13] = mkV(mkS(1, 0, 32'h0, 0, 0, 0, 0, 0, 0),                   0, 0, 32'h40,  0, 0, 0, 32'h55556666, 32'h11112222);

      s = z;
      s.rstN = 1'b0;
      applyStimulus(s);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i].s);
         checkOutput($sformatf("vec%0d.mem_cs", i), 32'(mem_cs), 32'(vecs[i].expCs));
         checkOutput($sformatf("vec%0d.mem_we", i), 32'(mem_we), 32'(vecs[i].expWe));
         checkOutput($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d.inst_stall", i), 32'(inst_stall), 32'(vecs[i].expIStall));
         checkOutput($sformatf("vec%0d.mem_stall", i), 32'(mem_stall), 32'(vecs[i].expMStall));
         checkOutput($sformatf("vec%0d.bus_err", i), 32'(bus_err), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d.inst_data", i), inst_data, vecs[i].expIData);
         checkOutput($sformatf("vec%0d.data_rdata", i), data_rdata, vecs[i].expDRdata);
         tick();
      end

      // Store with the acknowledge in the third grant cycle. The inputs
      // change under the grant, but the memory port must not.
      s = z;
      s.dataWen = 1'b1;
      s.dataAddr = 32'h8;
      s.dataWdata = 32'hCAFEF00D;
      applyStimulus(s);
      checkOutput("store.stall0", 32'(mem_stall), 32'd1);
      tick();
      for (int c = 1; c <= 3; c++) begin
         s.dataAddr  = 32'hFFF0 + 32'(c);
         s.dataWdata = 32'h12345678 + 32'(c);
         s.memAck    = (c == 3);
         s.memRdata  = 32'h99999999;
         applyStimulus(s);
         checkOutput($sformatf("store.c%0d.mem_cs", c), 32'(mem_cs), 32'd1);
         checkOutput($sformatf("store.c%0d.mem_we", c), 32'(mem_we), 32'd1);
         checkOutput($sformatf("store.c%0d.mem_addr", c), mem_addr, 32'h8);
         checkOutput($sformatf("store.c%0d.mem_wdata", c), mem_wdata, 32'hCAFEF00D);
         checkOutput($sformatf("store.c%0d.mem_stall", c), 32'(mem_stall), 32'd1);
         tick();
      end
      s.memAck = 1'b0;
      applyStimulus(s);
      checkOutput("store.done.mem_stall", 32'(mem_stall), 32'd0);
      checkOutput("store.done.mem_cs", 32'(mem_cs), 32'd0);
      checkOutput("store.done.data_rdata", data_rdata, 32'h11112222);
      checkOutput("store.done.bus_err", 32'(bus_err), 32'd0);
      tick();
      applyStimulus(z);
      tick();

      // Load with no acknowledge: abort after four grant cycles
      s = z;
      s.dataRen = 1'b1;
      s.dataAddr = 32'h200;
      applyStimulus(s);
      tick();
      for (int c = 1; c <= 4; c++) begin
         applyStimulus(s);
         checkOutput($sformatf("tmo.c%0d.mem_cs", c), 32'(mem_cs), 32'd1);
         checkOutput($sformatf("tmo.c%0d.bus_err", c), 32'(bus_err), 32'd0);
         checkOutput($sformatf("tmo.c%0d.mem_stall", c), 32'(mem_stall), 32'd1);
         tick();
      end
      applyStimulus(s);
      checkOutput("tmo.end.bus_err", 32'(bus_err), 32'd1);
      checkOutput("tmo.end.mem_cs", 32'(mem_cs), 32'd0);
      checkOutput("tmo.end.mem_stall", 32'(mem_stall), 32'd0);
      checkOutput("tmo.end.data_rdata", data_rdata, 32'h0);
      tick();
      applyStimulus(z);
      checkOutput("tmo.after.bus_err", 32'(bus_err), 32'd0);
      checkOutput("tmo.after.mem_cs", 32'(mem_cs), 32'd0);
      tick();

      // Acknowledge in the cycle the timeout would fire: normal completion
      s = z;
      s.instReq = 1'b1;
      s.instAddr = 32'h80;
      applyStimulus(s);
      tick();
      for (int c = 1; c <= 4; c++) begin
         s.memAck   = (c == 4);
         s.memRdata = 32'hABCD0123;
         applyStimulus(s);
         checkOutput($sformatf("race.c%0d.mem_cs", c), 32'(mem_cs), 32'd1);
         tick();
      end
      s.memAck = 1'b0;
      applyStimulus(s);
      checkOutput("race.bus_err", 32'(bus_err), 32'd0);
      checkOutput("race.inst_stall", 32'(inst_stall), 32'd0);
      checkOutput("race.inst_data", inst_data, 32'hABCD0123);
      tick();
      applyStimulus(z);
      tick();

      // Reset during an instruction access, then an acknowledge afterwards
      s = z;
      s.instReq = 1'b1;
      s.instAddr = 32'h90;
      applyStimulus(s);
      tick();
      s.rstN = 1'b0;
      applyStimulus(s);
      checkOutput("rstmid.mem_cs", 32'(mem_cs), 32'd1);
      checkOutput("rstmid.inst_stall", 32'(inst_stall), 32'd0);
      tick();
      s = z;
      s.memAck = 1'b1;
      s.memRdata = 32'h77777777;
      applyStimulus(s);
      checkOutput("rstmid.after.mem_cs", 32'(mem_cs), 32'd0);
      checkOutput("rstmid.after.inst_data", inst_data, 32'h0);
      checkOutput("rstmid.after.data_rdata", data_rdata, 32'h0);
      checkOutput("rstmid.after.mem_addr", mem_addr, 32'h0);
      checkOutput("rstmid.after.bus_err", 32'(bus_err), 32'd0);
      tick();
      s = z;
      s.instReq = 1'b1;
      s.instAddr = 32'h94;
      applyStimulus(s);
      checkOutput("rstmid.nodone.inst_stall", 32'(inst_stall), 32'd1);
      checkOutput("rstmid.nodone.inst_data", inst_data, 32'h0);
      checkOutput("rstmid.nodone.bus_err", 32'(bus_err), 32'd0);
      tick();
      s = z;
      s.memAck = 1'b1;
      s.memRdata = 32'h1;
      applyStimulus(s);
      tick();

      // Random phase against the model, starting from a reset
      s = z;
      s.rstN = 1'b0;
      applyStimulus(s);
      tick();
      mActive    = 1'b0;
      mIsData    = 1'b0;
      mAddr      = 32'h0;
      mWe        = 1'b0;
      mWdata     = 32'h0;
      mAge       = 0;
      mInstDone  = 1'b0;
      mDataDone  = 1'b0;
      mErr       = 1'b0;
      mInstData  = 32'h0;
      mDataRdata = 32'h0;
      s = z;
      for (int cyc = 0; cyc < 800; cyc++) begin
         s.rstN = ($urandom_range(49) != 0);
         if ($urandom_range(3) == 0) begin
            s.instReq  = ($urandom_range(1) == 1);
            s.instAddr = $urandom;
         end
         if ($urandom_range(3) == 0) begin
            s.dataRen   = ($urandom_range(1) == 1);
            s.dataWen   = ($urandom_range(2) == 0);
            s.dataAddr  = $urandom;
            s.dataWdata = $urandom;
         end
         s.memAck   = ($urandom_range(9) < 3);
         s.memRdata = $urandom;
         applyStimulus(s);
         checkOutput($sformatf("rnd%0d.mem_cs", cyc), 32'(mem_cs), 32'(mActive));
         if (mActive) begin
            checkOutput($sformatf("rnd%0d.mem_addr", cyc), mem_addr, mAddr);
            checkOutput($sformatf("rnd%0d.mem_we", cyc), 32'(mem_we), 32'(mWe));
            if (mWe) checkOutput($sformatf("rnd%0d.mem_wdata", cyc), mem_wdata, mWdata);
         end
         checkOutput($sformatf("rnd%0d.inst_stall", cyc), 32'(inst_stall),
                     32'(s.rstN & s.instReq & ~mInstDone));
         checkOutput($sformatf("rnd%0d.mem_stall", cyc), 32'(mem_stall),
                     32'(s.rstN & (s.dataRen | s.dataWen) & ~mDataDone));
         checkOutput($sformatf("rnd%0d.bus_err", cyc), 32'(bus_err), 32'(mErr));
         checkOutput($sformatf("rnd%0d.inst_data", cyc), inst_data, mInstData);
         checkOutput($sformatf("rnd%0d.data_rdata", cyc), data_rdata, mDataRdata);
         modelUpdate(s);
         if (!s.rstN) begin
            mInstDone = 1'b0;
            mDataDone = 1'b0;
            mErr      = 1'b0;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles a granted access waits for mem_ack before abort.
REQ-002 SHALL have port clk  input  1  main clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port inst_req  input  1  IF stage instruction read request.
REQ-005 SHALL have port inst_addr  input  32  instruction byte address.
REQ-006 SHALL have port inst_data  output  32  registered instruction read result.
REQ-007 SHALL have port inst_stall  output  1  IF must hold, to controller inst_stall.
REQ-008 SHALL have port data_ren  input  1  MEM stage load request.
REQ-009 SHALL have port data_wen  input  1  MEM stage store request.
REQ-010 SHALL have port data_addr  input  32  data byte address.
REQ-011 SHALL have port data_wdata  input  32  store data.
REQ-012 SHALL have port data_rdata  output  32  registered load result.
REQ-013 SHALL have port mem_stall  output  1  MEM must hold, to controller mem_stall.
REQ-014 SHALL have ports mem_cs/mem_we  output  1 each  shared port select / write strobe.
REQ-015 SHALL have ports mem_addr/mem_wdata  output  32 each  shared port address / write data.
REQ-016 SHALL have ports mem_rdata  input  32 and mem_ack  input  1  read data and completion from memory.
REQ-017 SHALL have port bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 SHALL implement FSM states IDLE, GNT_DATA, GNT_INST; one access in flight at a time.
REQ-019 In IDLE, data request (data_ren|data_wen) and no data_done SHALL go to GNT_DATA; else inst_req and no inst_done SHALL go to GNT_INST; else stay IDLE.
REQ-020 Data SHALL have fixed priority over instruction when both request in same IDLE cycle.
REQ-021 At grant, addr/we/wdata SHALL be latched into registers; mem_cs=1 and mem_addr/mem_we/mem_wdata SHALL stay stable while in GNT_* irrespective of input changes.
REQ-022 data_wen with data_ren SHALL be treated as store (mem_we=1); inst access always mem_we=0.
REQ-023 mem_ack sampled high in GNT_* SHALL complete access: rdata captured into inst_data or data_rdata (loads only; store leaves data_rdata unchanged), matching done flag set, state to IDLE.
REQ-024 mem_ack in IDLE SHALL be ignored.
REQ-025 inst_done/data_done SHALL be high exactly one cycle after completion, then clear.
REQ-026 inst_stall SHALL equal inst_req & ~inst_done; mem_stall SHALL equal (data_ren|data_wen) & ~data_done; both combinational.
REQ-027 Minimum latency: request seen cycle 0, mem_cs cycle 1, ack cycle 1, stall low cycle 2 with result valid.
REQ-028 Wait counter (8 bits minimum, wide enough for TIMEOUT) SHALL clear at grant, increment each GNT_* cycle without ack.
REQ-029 Counter reaching TIMEOUT without ack SHALL abort: state IDLE, bus_err pulsed 1 cycle, done flag set, result register loaded 32'h0.
REQ-030 Ack in the same cycle as timeout SHALL take precedence (normal completion, no bus_err).
REQ-031 Request held after its done cycle (requester stalled elsewhere) SHALL be re-issued as new access.
REQ-032 Request withdrawn while granted SHALL not abort; access completes, result captured, done pulse produced.

Reset
REQ-033 rst_n low at clock edge SHALL force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, inst_data=0, data_rdata=0, done flags 0, counter 0, bus_err=0.
REQ-034 While rst_n low, inst_stall and mem_stall SHALL be 0.
REQ-035 Reset mid-access SHALL drop mem_cs next cycle; an ack arriving after reset SHALL be ignored.

Verification
REQ-036 inst_req=1, inst_addr=0x40, mem_ack in first mem_cs cycle with mem_rdata=0x2108000A -> mem_cs 1 cycle, inst_stall low cycle 2, inst_data=0x2108000A.
REQ-037 inst_req and data_ren both at cycle 0, data_addr=0x100 -> mem_addr=0x100 first; inst access at 0x40 follows; mem_stall clears before inst_stall.
REQ-038 data_wen=1, data_addr=0x8, data_wdata=0xCAFEF00D, ack after 3 cycles -> mem_we=1, mem_wdata stable 3 cycles, data_rdata unchanged, mem_stall low cycle after ack.
REQ-039 TIMEOUT=4, data_ren, no ack -> bus_err single pulse after 4 grant cycles, data_rdata=0, mem_stall low that next cycle.
REQ-040 rst_n low during GNT_INST, ack asserted the following cycle -> mem_cs=0, inst_data=0, no done pulse, no bus_err.
